// File: rtl/adc_cap_pkg.sv
// Shared types and constants for the ADC capture scheduler.
// No logic; sizes the 3-channel, 4-bank (2048-word) capture window.
// Backpressure: n/a.
package adc_cap_pkg;

    localparam int NUM_CH    = 3;
    localparam int BANK_AW   = 9;
    localparam int NUM_BANKS = 4;
    localparam int WIN_AW    = 11;
    localparam int CNT_W     = 12;
    localparam int DAT_W     = 32;
    localparam int CH_IDX_W  = 2;

    // Channel tag lives in the top two data bits when tagging is built in.
    localparam int TAG_MSB = 31;
    localparam int TAG_LSB = 30;

    localparam logic [CNT_W-1:0] WIN_WORDS = CNT_W'(NUM_BANKS << BANK_AW);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic [NUM_BANKS-1:0] wenb;
        logic [BANK_AW-1:0]   addr;
        logic [DAT_W-1:0]     dat;
    } mem_wr_t;

endpackage

// File: rtl/adc_cap_rr_arb.sv
// Round-robin arbiter over the channel hold buffers, one-hot grant.
// Latency: combinational grant; pointer advances on the clock after a grant.
// Backpressure: none; requests simply wait until they win.
module adc_cap_rr_arb
    import adc_cap_pkg::*;
(
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic [NUM_CH-1:0]   req,
    output logic [NUM_CH-1:0]   gnt,
    output logic [CH_IDX_W-1:0] gnt_idx,
    output logic                gnt_vld
);

    localparam int CW = CH_IDX_W + 1;

    logic [CH_IDX_W-1:0] ptr_q;
    logic [CW-1:0]       cand;

    // ptr_q holds the highest-priority channel; scan from there with wrap.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= CW'(NUM_CH)) begin
                cand = cand - CW'(NUM_CH);
            end
            if (!gnt_vld && req[cand[CH_IDX_W-1:0]]) begin
                gnt[cand[CH_IDX_W-1:0]] = 1'b1;
                gnt_idx                 = cand[CH_IDX_W-1:0];
                gnt_vld                 = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ptr_q <= '0;
        end else if (gnt_vld) begin
            ptr_q <= (gnt_idx == CH_IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/adc_capture_sched.sv
// Buffers sinc3 samples per channel and packs them linearly into 4 SRAM banks; ADC_CAP_TAG_EN tags data[31:30].
// Latency: dvalid in cycle n -> bank write strobe in cycle n+2 when uncontested.
// Backpressure: none upstream; a sample arriving on a still-full hold is dropped and flagged in overflow_o.
module adc_capture_sched
    import adc_cap_pkg::*;
(
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [NUM_CH-1:0]    ch_en_i,
    input  logic [CNT_W-1:0]     depth_i,
    input  logic [NUM_CH-1:0]    adc_dvalid_i,
    input  logic [DAT_W-1:0]     adc0_dat_i,
    input  logic [DAT_W-1:0]     adc1_dat_i,
    input  logic [DAT_W-1:0]     adc2_dat_i,
    output logic [NUM_BANKS-1:0] mem_wenb_o,
    output logic [BANK_AW-1:0]   mem_waddr_o,
    output logic [DAT_W-1:0]     mem_data_o,
    output logic [3:0]           wmask_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [NUM_CH-1:0]    overflow_o,
    output logic [CNT_W-1:0]     wr_count_o
);

    cap_state_e          state_q, state_d;
    logic [NUM_CH-1:0]   ch_en_q;
    logic [NUM_CH-1:0]   hold_vld_q;
    logic [NUM_CH-1:0]   ovf_q;
    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   gnt;
    logic [CNT_W-1:0]    depth_q;
    logic [CNT_W-1:0]    wr_count_q;
    logic [DAT_W-1:0]    hold_dat_q [NUM_CH];
    logic [DAT_W-1:0]    adc_dat    [NUM_CH];
    logic [CH_IDX_W-1:0] gnt_idx;
    logic                gnt_vld;
    logic                in_cap;
    logic                start_go;
    logic                last_wr;
    logic [DAT_W-1:0]    wr_dat;
    mem_wr_t             wr_q;

    assign adc_dat[0] = adc0_dat_i;
    assign adc_dat[1] = adc1_dat_i;
    assign adc_dat[2] = adc2_dat_i;

    assign in_cap   = (state_q == ST_CAPTURE);
    assign start_go = start_i && !in_cap;
    // Once the window is full no further grant may consume a hold.
    assign req      = (in_cap && (wr_count_q != depth_q)) ? hold_vld_q : '0;
    assign last_wr  = gnt_vld && ((wr_count_q + 1'b1) == depth_q);

    adc_cap_rr_arb u_arb (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_vld   (gnt_vld)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (abort_i)      state_d = ST_IDLE;
                else if (last_wr) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_dat = hold_dat_q[gnt_idx];
`ifdef ADC_CAP_TAG_EN
        wr_dat[TAG_MSB:TAG_LSB] = gnt_idx;
`endif
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= ST_IDLE;
            ch_en_q    <= '0;
            depth_q    <= '0;
            wr_count_q <= '0;
            hold_vld_q <= '0;
            ovf_q      <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                hold_dat_q[ch] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (start_go) begin
                ch_en_q    <= ch_en_i;
                depth_q    <= (depth_i == '0) ? WIN_WORDS : depth_i;
                wr_count_q <= '0;
                hold_vld_q <= '0;
                ovf_q      <= '0;
            end else begin
                if (gnt_vld) wr_count_q <= wr_count_q + 1'b1;
                // state_d stays CAPTURE here only if state_q already was.
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (state_d != ST_CAPTURE) begin
                        hold_vld_q[ch] <= 1'b0;
                    end else if (adc_dvalid_i[ch] && ch_en_q[ch]) begin
                        if (!hold_vld_q[ch] || gnt[ch]) begin
                            hold_vld_q[ch] <= 1'b1;
                            hold_dat_q[ch] <= adc_dat[ch];
                        end else begin
                            ovf_q[ch] <= 1'b1;
                        end
                    end else if (gnt[ch]) begin
                        hold_vld_q[ch] <= 1'b0;
                    end
                end
            end
        end
    end

    // Write stage is independent of the FSM so a granted word always lands.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_q <= '{wenb: '1, addr: '0, dat: '0};
        end else begin
            wr_q.wenb <= '1;
            if (gnt_vld) begin
                wr_q.wenb <= ~(NUM_BANKS'(1) << wr_count_q[WIN_AW-1:BANK_AW]);
                wr_q.addr <= wr_count_q[BANK_AW-1:0];
                wr_q.dat  <= wr_dat;
            end
        end
    end

    assign mem_wenb_o  = wr_q.wenb;
    assign mem_waddr_o = wr_q.addr;
    assign mem_data_o  = wr_q.dat;
    assign wmask_o     = 4'hF;
    assign busy_o      = in_cap;
    assign done_o      = (state_q == ST_DONE);
    assign overflow_o  = ovf_q;
    assign wr_count_o  = wr_count_q;

endmodule
